// File: rtl/dmaRegConfigPkg.sv
// Shared types and helpers for the DMA channel arbiter.
//   CHANNELS_DEF  : default channel count
//   arbState_t    : bus-hold sequencer states
//   DACK_INACTIVE : idle level of a DACK line for a given polarity
package dmaRegConfigPkg;

  localparam int CHANNELS_DEF = 4;

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    REQ     = 2'd1,
    GRANT   = 2'd2,
    RELEASE = 2'd3
  } arbState_t;

  // Idle level of a DACK line: low when DACK is active-high, else high.
  function automatic logic DACK_INACTIVE(input logic act_high);
    return ~act_high;
  endfunction

endpackage

// File: rtl/dma_priority_resolver.sv
// Combinational priority resolver.
//   i_req   : effective (polarity-corrected, unmasked) requests
//   i_top   : highest-priority channel (0 for fixed priority)
//   o_found : at least one request present
//   o_win   : winning channel index
// The request vector is rotated so that i_top lands at bit 0, the lowest
// set bit is found, and the index is rotated back.
module dma_priority_resolver #(
  parameter  int CHANNELS = 4,
  localparam int CHW      = $clog2(CHANNELS)
) (
  input  logic [CHANNELS-1:0] i_req,
  input  logic [CHW-1:0]      i_top,
  output logic                o_found,
  output logic [CHW-1:0]      o_win
);

  logic [CHANNELS-1:0] w_rot;
  logic [CHW-1:0]      w_pos;

  always_comb begin
    w_rot = '0;
    for (int i = 0; i < CHANNELS; i++) begin
      int idx;
      idx = i + int'(i_top);
      if (idx >= CHANNELS) idx = idx - CHANNELS;
      w_rot[i] = i_req[idx];
    end
  end

  always_comb begin
    int sum;
    w_pos   = '0;
    o_found = 1'b0;
    // Scan downwards so the last hit is the lowest set bit.
    for (int i = CHANNELS - 1; i >= 0; i--) begin
      if (w_rot[i]) begin
        w_pos   = CHW'(i);
        o_found = 1'b1;
      end
    end
    sum = int'(w_pos) + int'(i_top);
    if (sum >= CHANNELS) sum = sum - CHANNELS;
    o_win = CHW'(sum);
  end

endmodule

// File: rtl/dma_channel_arbiter.sv
// DMA request arbiter and HRQ/HLDA bus-hold sequencer.
//   CLK, RESET_N        : clock, async active-low reset
//   DREQ, DREQ_ACT_LOW  : channel requests and their polarity
//   HLDA                : hold acknowledge from the CPU
//   EOP_N, XFER_DONE    : end-of-process, per-transfer completion pulse
//   ROTATING            : rotating (1) / fixed (0) priority
//   SINGLE_MODE         : release after every transfer (1) / demand (0)
//   AUTOINIT            : per-channel, suppresses EOP auto-masking
//   MASK_WE, MASK_WDATA : full mask register write
//   HRQ                 : hold request
//   DACK, DACK_ACT_HIGH : one-hot acknowledge and its polarity
//   GRANT_VALID/CH      : current bus owner
//   MASK                : mask register
module dma_channel_arbiter
  import dmaRegConfigPkg::*;
#(
  parameter  int CHANNELS = CHANNELS_DEF,
  localparam int CHW      = $clog2(CHANNELS)
) (
  input  logic                CLK,
  input  logic                RESET_N,
  input  logic [CHANNELS-1:0] DREQ,
  input  logic                HLDA,
  input  logic                EOP_N,
  input  logic                XFER_DONE,
  input  logic                ROTATING,
  input  logic                SINGLE_MODE,
  input  logic                DREQ_ACT_LOW,
  input  logic                DACK_ACT_HIGH,
  input  logic [CHANNELS-1:0] AUTOINIT,
  input  logic                MASK_WE,
  input  logic [CHANNELS-1:0] MASK_WDATA,
  output logic                HRQ,
  output logic [CHANNELS-1:0] DACK,
  output logic                GRANT_VALID,
  output logic [CHW-1:0]      GRANT_CH,
  output logic [CHANNELS-1:0] MASK
);

  arbState_t           r_state;
  logic                r_hrq;
  logic [CHANNELS-1:0] r_dack;
  logic                r_gv;
  logic [CHW-1:0]      r_gch;
  logic [CHANNELS-1:0] r_mask;
  logic [CHW-1:0]      r_top;

  logic [CHANNELS-1:0] w_req;
  logic [CHANNELS-1:0] w_dack_idle;
  logic [CHANNELS-1:0] w_win_oh;
  logic [CHANNELS-1:0] w_gch_oh;
  logic [CHANNELS-1:0] w_eop_set;
  logic [CHW-1:0]      w_top_eff;
  logic [CHW-1:0]      w_top_next;
  logic [CHW-1:0]      w_win;
  logic                w_found;
  logic                w_in_grant;
  logic                w_release;

  assign w_req       = (DREQ ^ {CHANNELS{DREQ_ACT_LOW}}) & ~r_mask;
  assign w_dack_idle = {CHANNELS{DACK_INACTIVE(DACK_ACT_HIGH)}};
  assign w_win_oh    = CHANNELS'(1) << w_win;
  assign w_gch_oh    = CHANNELS'(1) << r_gch;
  // Pointer is kept when fixed priority is selected, just not used.
  assign w_top_eff   = ROTATING ? r_top : '0;
  assign w_top_next  = (r_gch == CHW'(CHANNELS - 1)) ? '0 : r_gch + CHW'(1);

  // HLDA low in GRANT is a bus revoke and takes precedence over release.
  assign w_in_grant = (r_state == GRANT) && HLDA;
  assign w_release  = !EOP_N || (XFER_DONE && (SINGLE_MODE || !w_req[r_gch]));
  assign w_eop_set  = (w_in_grant && !EOP_N && !AUTOINIT[r_gch]) ? w_gch_oh : '0;

  dma_priority_resolver #(.CHANNELS(CHANNELS)) u_resolver (
    .i_req   (w_req),
    .i_top   (w_top_eff),
    .o_found (w_found),
    .o_win   (w_win)
  );

  always_ff @(posedge CLK or negedge RESET_N) begin
    if (!RESET_N) begin
      r_state <= IDLE;
      r_hrq   <= 1'b0;
      r_dack  <= w_dack_idle;
      r_gv    <= 1'b0;
      r_gch   <= '0;
      r_mask  <= '1;
      r_top   <= '0;
    end else begin
      // A software write and an EOP auto-mask in the same cycle merge.
      r_mask <= (MASK_WE ? MASK_WDATA : r_mask) | w_eop_set;
      case (r_state)
        IDLE: begin
          if (|w_req) begin
            r_state <= REQ;
            r_hrq   <= 1'b1;
          end
        end
        REQ: begin
          if (HLDA) begin
            if (w_found) begin
              r_state <= GRANT;
              r_dack  <= DACK_ACT_HIGH ? w_win_oh : ~w_win_oh;
              r_gch   <= w_win;
              r_gv    <= 1'b1;
            end else begin
              r_state <= RELEASE;
              r_hrq   <= 1'b0;
            end
          end
        end
        GRANT: begin
          if (!HLDA) begin
            r_state <= IDLE;
            r_hrq   <= 1'b0;
            r_dack  <= w_dack_idle;
            r_gv    <= 1'b0;
          end else if (w_release) begin
            r_state <= RELEASE;
            r_hrq   <= 1'b0;
            r_dack  <= w_dack_idle;
            r_gv    <= 1'b0;
            if (ROTATING) r_top <= w_top_next;
          end
        end
        RELEASE: begin
          if (!HLDA) r_state <= IDLE;
        end
        default: r_state <= IDLE;
      endcase
    end
  end

  assign HRQ         = r_hrq;
  assign DACK        = r_dack;
  assign GRANT_VALID = r_gv;
  assign GRANT_CH    = r_gch;
  assign MASK        = r_mask;

endmodule

// File: tb/tb_dma_channel_arbiter.sv
// Self-checking bench for dma_channel_arbiter (4 channels).
// Inputs are driven on the falling edge; outputs produced by the next rising
// edge are checked on the following falling edge via an expectation queue.
module tb_dma_channel_arbiter;

  logic       CLK = 1'b0;
  logic       RESET_N = 1'b0;
  logic [3:0] DREQ = '0;
  logic       HLDA = 1'b0, EOP_N = 1'b1, XFER_DONE = 1'b0;
  logic       ROTATING = 1'b0, SINGLE_MODE = 1'b0;
  logic       DREQ_ACT_LOW = 1'b0, DACK_ACT_HIGH = 1'b1;
  logic [3:0] AUTOINIT = '0;
  logic       MASK_WE = 1'b0;
  logic [3:0] MASK_WDATA = '0;
  logic       HRQ, GRANT_VALID;
  logic [3:0] DACK, MASK;
  logic [1:0] GRANT_CH;

  dma_channel_arbiter dut (
    .CLK(CLK), .RESET_N(RESET_N), .DREQ(DREQ), .HLDA(HLDA), .EOP_N(EOP_N),
    .XFER_DONE(XFER_DONE), .ROTATING(ROTATING), .SINGLE_MODE(SINGLE_MODE),
    .DREQ_ACT_LOW(DREQ_ACT_LOW), .DACK_ACT_HIGH(DACK_ACT_HIGH),
    .AUTOINIT(AUTOINIT), .MASK_WE(MASK_WE), .MASK_WDATA(MASK_WDATA),
    .HRQ(HRQ), .DACK(DACK), .GRANT_VALID(GRANT_VALID), .GRANT_CH(GRANT_CH),
    .MASK(MASK)
  );

  always #5 CLK = ~CLK;

  typedef struct {
    string      nm;
    logic [3:0] dreq;
    logic       hlda, eop_n, xfer, mwe;
    logic [3:0] mwd;
    logic       e_hrq;
    logic [3:0] e_dack;
    logic       e_gv;
    logic [1:0] e_gch;
    logic [3:0] e_mask;
  } vec_t;

  vec_t tv[$];
  vec_t exp_q[$];
  int   n_chk = 0;
  int   n_err = 0;
  bit   dack_hi = 1'b1;

  function automatic logic [3:0] oh(int ch);
    logic [3:0] t;
    t = 4'b0001;
    t = t << ch;
    return dack_hi ? t : ~t;
  endfunction

  function automatic logic [3:0] none();
    return dack_hi ? 4'b0000 : 4'b1111;
  endfunction

  function automatic vec_t mk(string nm, logic [3:0] dreq, logic hlda,
                              logic eop_n, logic xfer, logic mwe,
                              logic [3:0] mwd, logic e_hrq, logic [3:0] e_dack,
                              logic e_gv, logic [1:0] e_gch, logic [3:0] e_mask);
    vec_t v;
    v.nm = nm; v.dreq = dreq; v.hlda = hlda; v.eop_n = eop_n; v.xfer = xfer;
    v.mwe = mwe; v.mwd = mwd; v.e_hrq = e_hrq; v.e_dack = e_dack;
    v.e_gv = e_gv; v.e_gch = e_gch; v.e_mask = e_mask;
    return v;
  endfunction

  task automatic chk(string nm, logic [3:0] act, logic [3:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s actual=%b expected=%b at %0t", nm, act, exp, $time);
    end
  endtask

  task automatic cmp(vec_t e);
    chk({e.nm, ".hrq"},  {3'b0, HRQ},         {3'b0, e.e_hrq});
    chk({e.nm, ".dack"}, DACK,                e.e_dack);
    chk({e.nm, ".gv"},   {3'b0, GRANT_VALID}, {3'b0, e.e_gv});
    if (e.e_gv) chk({e.nm, ".gch"}, {2'b0, GRANT_CH}, {2'b0, e.e_gch});
    chk({e.nm, ".mask"}, MASK,                e.e_mask);
  endtask

  // Apply each row, queue its expectation, compare after the next edge.
  task automatic run_table();
    foreach (tv[k]) begin
      vec_t e;
      DREQ = tv[k].dreq; HLDA = tv[k].hlda; EOP_N = tv[k].eop_n;
      XFER_DONE = tv[k].xfer; MASK_WE = tv[k].mwe; MASK_WDATA = tv[k].mwd;
      exp_q.push_back(tv[k]);
      @(negedge CLK);
      e = exp_q.pop_front();
      cmp(e);
    end
    tv.delete();
  endtask

  initial begin
    #100000;
    $display("FAIL timeout");
    $fatal(1);
  end

  initial begin
    vec_t e;
    // Reset state
    repeat (2) @(negedge CLK);
    cmp(mk("reset", 0, 0, 1, 0, 0, 0, 0, none(), 0, 0, 4'b1111));
    RESET_N = 1'b1;

    // Fixed priority, late HLDA: ch1 beats ch2
    tv.push_back(mk("s1.mclr",  4'b0000, 0, 1, 0, 1, 0, 0, none(), 0, 0, 0));
    tv.push_back(mk("s1.dreq2", 4'b0100, 0, 1, 0, 0, 0, 1, none(), 0, 0, 0));
    for (int i = 0; i < 3; i++)
      tv.push_back(mk($sformatf("s1.wait%0d", i), 4'b0110, 0, 1, 0, 0, 0, 1, none(), 0, 0, 0));
    tv.push_back(mk("s1.grant", 4'b0110, 1, 1, 0, 0, 0, 1, oh(1), 1, 1, 0));
    tv.push_back(mk("s1.hold",  4'b0110, 1, 1, 1, 0, 0, 1, oh(1), 1, 1, 0));
    tv.push_back(mk("s1.rel",   4'b0100, 1, 1, 1, 0, 0, 0, none(), 0, 0, 0));
    tv.push_back(mk("s1.idle",  4'b0000, 0, 1, 0, 0, 0, 0, none(), 0, 0, 0));
    run_table();

    // Rotating priority, single mode: 0,1,2,3,0
    ROTATING = 1'b1; SINGLE_MODE = 1'b1;
    for (int i = 0; i < 5; i++) begin
      tv.push_back(mk($sformatf("s2.hrq%0d", i),   4'b1111, 0, 1, 0, 0, 0, 1, none(), 0, 0, 0));
      tv.push_back(mk($sformatf("s2.grant%0d", i), 4'b1111, 1, 1, 0, 0, 0, 1, oh(i % 4), 1, 2'(i % 4), 0));
      tv.push_back(mk($sformatf("s2.done%0d", i),  4'b1111, 1, 1, 1, 0, 0, 0, none(), 0, 0, 0));
      tv.push_back(mk($sformatf("s2.idle%0d", i),  4'b1111, 0, 1, 0, 0, 0, 0, none(), 0, 0, 0));
    end
    run_table();

    // Demand mode on ch3: one grant for four transfers
    ROTATING = 1'b0; SINGLE_MODE = 1'b0;
    tv.push_back(mk("s3.hrq",   4'b1000, 0, 1, 0, 0, 0, 1, none(), 0, 0, 0));
    tv.push_back(mk("s3.grant", 4'b1000, 1, 1, 0, 0, 0, 1, oh(3), 1, 3, 0));
    for (int i = 0; i < 3; i++)
      tv.push_back(mk($sformatf("s3.xfer%0d", i), 4'b1000, 1, 1, 1, 0, 0, 1, oh(3), 1, 3, 0));
    tv.push_back(mk("s3.drop",  4'b0000, 1, 1, 0, 0, 0, 1, oh(3), 1, 3, 0));
    tv.push_back(mk("s3.last",  4'b0000, 1, 1, 1, 0, 0, 0, none(), 0, 0, 0));
    tv.push_back(mk("s3.idle",  4'b0000, 0, 1, 0, 0, 0, 0, none(), 0, 0, 0));
    run_table();

    // EOP auto-mask on ch1, merged with a same-cycle mask write
    AUTOINIT = 4'b0000;
    tv.push_back(mk("s4.hrq",    4'b0010, 0, 1, 0, 0, 0,       1, none(), 0, 0, 0));
    tv.push_back(mk("s4.grant",  4'b0010, 1, 1, 0, 0, 0,       1, oh(1), 1, 1, 0));
    tv.push_back(mk("s4.eop",    4'b0010, 1, 0, 0, 1, 4'b0100, 0, none(), 0, 0, 4'b0110));
    tv.push_back(mk("s4.idle",   4'b0010, 0, 1, 0, 0, 0,       0, none(), 0, 0, 4'b0110));
    tv.push_back(mk("s4.masked", 4'b0010, 0, 1, 0, 0, 0,       0, none(), 0, 0, 4'b0110));
    tv.push_back(mk("s4.clr",    4'b0000, 0, 1, 0, 1, 0,       0, none(), 0, 0, 0));
    run_table();
    AUTOINIT = 4'b0010;
    tv.push_back(mk("s4a.hrq",   4'b0010, 0, 1, 0, 0, 0, 1, none(), 0, 0, 0));
    tv.push_back(mk("s4a.grant", 4'b0010, 1, 1, 0, 0, 0, 1, oh(1), 1, 1, 0));
    tv.push_back(mk("s4a.eop",   4'b0010, 1, 0, 0, 0, 0, 0, none(), 0, 0, 0));
    tv.push_back(mk("s4a.idle",  4'b0000, 0, 1, 0, 0, 0, 0, none(), 0, 0, 0));
    run_table();
    AUTOINIT = 4'b0000;

    // Inverted polarities; change them only under reset
    RESET_N = 1'b0;
    DREQ_ACT_LOW = 1'b1; DACK_ACT_HIGH = 1'b0; dack_hi = 1'b0;
    DREQ = 4'b1111; HLDA = 1'b0;
    @(negedge CLK);
    cmp(mk("s5.reset", 0, 0, 1, 0, 0, 0, 0, 4'b1111, 0, 0, 4'b1111));
    RESET_N = 1'b1;
    ROTATING = 1'b1;
    tv.push_back(mk("s5.clr",    4'b1111, 0, 1, 0, 1, 0, 0, none(), 0, 0, 0));
    tv.push_back(mk("s5.hrq",    4'b1011, 0, 1, 0, 0, 0, 1, none(), 0, 0, 0));
    tv.push_back(mk("s5.grant",  4'b1011, 1, 1, 0, 0, 0, 1, oh(2), 1, 2, 0));
    tv.push_back(mk("s5.revoke", 4'b1011, 0, 1, 0, 0, 0, 0, 4'b1111, 0, 0, 0));
    // ch1 and ch3 request: ch1 wins only if top stayed at 0
    tv.push_back(mk("s5.rehrq",  4'b0101, 0, 1, 0, 0, 0, 1, none(), 0, 0, 0));
    tv.push_back(mk("s5.grant2", 4'b0101, 1, 1, 0, 0, 0, 1, oh(1), 1, 1, 0));
    run_table();

    // Asynchronous reset mid-grant, checked before any clock edge
    #2;
    RESET_N = 1'b0;
    #1;
    e = mk("s5.areset", 0, 0, 1, 0, 0, 0, 0, 4'b1111, 0, 0, 4'b1111);
    cmp(e);
    @(negedge CLK);
    e.nm = "s5.areset_hold";
    cmp(e);
    RESET_N = 1'b1;
    @(negedge CLK);

    $display("CHECKS %0d ERRORS %0d", n_chk, n_err);
    $finish;
  end

endmodule

// File: doc/dma_channel_arbiter.md
# dma_channel_arbiter

Parametrised DMA request arbiter and hold-request sequencer for the DMA controller, successor to the fixed four-channel priority logic. It accepts per-channel DREQ, runs the HRQ/HLDA bus-hold handshake with the CPU, and resolves fixed or rotating priority across `CHANNELS` requesters. It drives one-hot DACK with programmable polarity and maintains the channel mask register, including EOP auto-masking. It sits between the bus interface pins and the timing-and-control block, which reports per-transfer completion through `XFER_DONE`.

## Interface
Parameters:
- `CHANNELS`, 4, number of DMA channels; legal range 2..16.
- `CHW`, `$clog2(CHANNELS)`, width of the channel index; derived, not overridden.

Ports (one clock; reset is asynchronous and active-low):
- `CLK` in 1: system clock; all state changes on the rising edge.
- `RESET_N` in 1: asynchronous, active-low reset.
- `DREQ` in CHANNELS: channel requests; polarity set by `DREQ_ACT_LOW`.
- `HLDA` in 1: hold acknowledge from the CPU.
- `EOP_N` in 1: end of process, active low; sampled only in GRANT.
- `XFER_DONE` in 1: one-cycle pulse from timing/control marking the end of one transfer.
- `ROTATING` in 1: 1 selects rotating priority, 0 selects fixed priority.
- `SINGLE_MODE` in 1: 1 releases the bus after every transfer, 0 selects demand mode.
- `DREQ_ACT_LOW` in 1, `DACK_ACT_HIGH` in 1: polarity controls; static while `RESET_N` is deasserted.
- `AUTOINIT` in CHANNELS: per-channel flag; when set, EOP does not mask the channel.
- `MASK_WE` in 1, `MASK_WDATA` in CHANNELS: full mask register write.
- `HRQ` out 1: hold request.
- `DACK` out CHANNELS: one-hot acknowledge at the selected polarity.
- `GRANT_VALID` out 1, `GRANT_CH` out CHW: indicate the channel that currently owns the bus.
- `MASK` out CHANNELS: current mask register.

## Operation
- An effective request is `req[i] = (DREQ[i] ^ DREQ_ACT_LOW) & ~MASK[i]`.
- State machine: IDLE → REQ → GRANT → RELEASE → IDLE.
  - IDLE: if `|req`, go to REQ and set HRQ to 1.
  - REQ: HRQ is held; a hold request is never withdrawn before HLDA. When HLDA=1, resolve the winner from `req` in that cycle.
    - If a winner exists: go to GRANT, assert `DACK[w]`, set `GRANT_CH`=w and `GRANT_VALID`=1.
    - If `req`=0: go to RELEASE.
  - GRANT: leave for RELEASE on any of the following:
    - EOP_N=0;
    - SINGLE_MODE=1 and XFER_DONE=1;
    - SINGLE_MODE=0, XFER_DONE=1, and `req[GRANT_CH]`=0.
  - GRANT with HLDA=0 (bus revoked): go directly to IDLE. DACK is deasserted, HRQ=0, GRANT_VALID=0, and neither the mask nor the rotation pointer is updated.
  - RELEASE: HRQ=0, DACK inactive, GRANT_VALID=0. Stay until HLDA=0, then go to IDLE.
- Priority:
  - Fixed: channel 0 is highest priority.
  - Rotating: a pointer `top` names the highest-priority channel. On GRANT→RELEASE, `top` is set to `(GRANT_CH+1) mod CHANNELS`; the wrap from CHANNELS-1 goes to 0.
  - The pointer is updated only in rotating mode and is retained across mode switches.
- Mask register:
  - On EOP_N=0 in GRANT with `AUTOINIT[GRANT_CH]`=0, `MASK[GRANT_CH]` is set.
  - When MASK_WE and the EOP set occur in the same cycle, the result is `MASK_WDATA | eop_set`.
  - If a mask write masks the granted channel, the channel finishes its current transfer and demand mode then releases at XFER_DONE.
- DREQ changes during GRANT never change the granted channel. There is no preemption.

## Timing
- All outputs are registered.
- Reset values: state IDLE, HRQ=0, DACK all inactive (`{CHANNELS{~DACK_ACT_HIGH}}`), GRANT_VALID=0, GRANT_CH=0, MASK all ones, `top`=0.
- DREQ sampled active at edge k gives HRQ=1 after edge k.
- HLDA sampled high at edge m gives DACK/GRANT_VALID valid after edge m.
- Minimum latency from request to DACK is 2 cycles, with HLDA tied high.
- A release condition sampled at edge n deasserts DACK and HRQ after edge n.
- A new HRQ cannot assert until HLDA has been seen low.
- Asserting reset in any state forces the reset values immediately, without waiting for a clock edge.

## Structure
- `dmaRegConfigPkg` holds:
  - `CHANNELS` default;
  - `arbState_t` enum {IDLE, REQ, GRANT, RELEASE};
  - `DACK_INACTIVE` helper function.
- Sub-module `dma_priority_resolver`: combinational. Inputs are `req` and `top`, with `top` forced to 0 when fixed priority is selected. Outputs are `found` and the winner index. It rotates `req` by `top`, finds the lowest set bit, and un-rotates the index.
- The top level contains the FSM, the mask register, the pointer register and the polarity logic.

## Test plan
- Reset, then write MASK_WDATA=0 with the fixed default of 4 channels. Assert DREQ[2], then DREQ[1]; HLDA rises 3 cycles after HRQ. Required: HRQ one cycle after DREQ, DACK=4'b0010 one cycle after HLDA, GRANT_CH=1.
- Rotating mode with DREQ=4'b1111, single mode, XFER_DONE each grant, HLDA acknowledging every request. Required grant order 0,1,2,3,0; each winner is the next channel after the previous one, wrapping from 3 to 0.
- Demand mode on channel 3 with 3 XFER_DONE pulses while DREQ[3] is held, then DREQ[3] drops and one more XFER_DONE arrives. Required: a single grant covering all 4 transfers; release on the 4th XFER_DONE.
- EOP_N low during a grant to channel 1, with AUTOINIT=0, then again with AUTOINIT[1]=1. Required: MASK[1]=1 after the first release; MASK[1] stays 0 in the AUTOINIT case.
- HLDA dropped mid-GRANT, and separately reset asserted mid-GRANT, with DREQ_ACT_LOW=1 and DACK_ACT_HIGH=0. Required: DACK returns to 4'b1111 and HRQ=0. Reset restores MASK=4'b1111 asynchronously; the bus-revoke case leaves `top` unchanged.
